frame_scanout_reader: RTL and testbench
=======================================

Name: frame_scanout_reader

Overview:
- Avalon-MM burst-read master that streams a completed frame buffer out of SDRAM toward the VGA pixel path.
- It is the consumer end of the frame buffer that the drawing unit and blitter write.
- On each frame_start it latches the frame base, issues linear bursts over the frame, buffers the words in an internal FIFO, and presents them on a valid/ready word stream.
- It flags underflow if the display side asks for data that has not arrived.

Parameters:
FRAME_WORDS, 153600, 32-bit words per frame (640x480, two 16-bit pixels per word)
BURST_LEN, 16, maximum beats per burst (1..16; fits 5-bit burstcount)
FIFO_DEPTH, 64, word FIFO depth; power of two, >= 2*BURST_LEN

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
frame_address  in  32  byte base address of the frame to display; sampled on frame_start
frame_start  in  1  single-cycle pulse at vertical blank; begins a new frame
avalon_master_address  out  32  byte address of burst start
avalon_master_burstcount  out  5  beats in current burst
avalon_master_byteenable  out  4  constant 4'hF
avalon_master_read  out  1  read request
avalon_master_readdata  in  32  returned word
avalon_master_readdatavalid  in  1  readdata qualifier
avalon_master_waitrequest  in  1  slave stall
pix_data  out  32  FIFO head word
pix_valid  out  1  FIFO non-empty
pix_ready  in  1  consumer takes head word when pix_valid&pix_ready
pix_sof  out  1  high with first word of a frame
underflow  out  1  sticky: pix_ready high while pix_valid low during an active frame; cleared by frame_start
frame_done  out  1  one-cycle pulse when the last word of a frame has been received from memory

Behaviour:
- Reset, asynchronous: state IDLE; read=0; address=0; burstcount=0; FIFO empty; pix_valid=0; pix_sof=0; underflow=0; frame_done=0; word counters=0.
- States:
  - IDLE: wait for frame_start.
  - ISSUE: hold read/address/burstcount until waitrequest is low.
  - RECEIVE: count readdatavalid beats into the FIFO.
  - DRAIN: discard beats still outstanding from an aborted burst.
- frame_start in any state:
  - Latch frame_address into base.
  - Clear the issued-word and received-word counters.
  - Flush the FIFO. pix_valid drops the next cycle.
  - Clear underflow.
  - Arm pix_sof for the next word written.
- Where frame_start lands:
  - In IDLE or RECEIVE with 0 beats outstanding: go to ISSUE.
  - In ISSUE (command not yet accepted): abandon the command. Deassert read the next cycle, re-evaluate, then go to ISSUE with the new base.
  - In RECEIVE with beats outstanding: go to DRAIN. Discard exactly the remaining beats, then go to ISSUE. Discarded beats never enter the FIFO.
- Burst issue condition: FIFO_DEPTH - fifo_count >= BURST_LEN and issued < FRAME_WORDS.
  - burstcount = min(BURST_LEN, FRAME_WORDS - issued).
  - address = base + 4*issued, 32-bit wrap.
- Command acceptance: read stays asserted with stable address and burstcount until a cycle with waitrequest=0. In that cycle, issued += burstcount and the state moves to RECEIVE.
- Only one burst is outstanding at a time.
- RECEIVE: each readdatavalid beat writes readdata into the FIFO. After the last beat:
  - If received == FRAME_WORDS: pulse frame_done and go to IDLE.
  - Otherwise return to ISSUE when the issue condition holds; stay in RECEIVE (idle) until then.
- FIFO:
  - Push and pop in the same cycle leave the count unchanged.
  - No push when full; the space check guarantees this.
  - pix_data and pix_sof are registered head values, valid in the same cycle as pix_valid.
  - The first-word latency from accepted read is memory latency + 1 cycle.
- pix_sof travels with the word in the FIFO; it is high only for word 0 of each frame.
- underflow is set when pix_ready=1, pix_valid=0, and the frame is active (after frame_start, before all words are popped). It holds until reset or frame_start.
- readdatavalid in IDLE is ignored.

Test Plan:
- Ideal memory (latency 2, no waitrequest), FRAME_WORDS=40, BURST_LEN=16, frame_address=0x0010_0000, pix_ready=1 -> bursts at 0x100000/16, 0x100040/16, 0x100080/8. pix_data sequence matches memory, pix_sof only on word 0, one frame_done pulse, underflow stays 0 after first word.
- waitrequest high 5 cycles on the 2nd burst -> address/burstcount/read held stable all 5 cycles, exactly one burst accepted, no duplicate data.
- pix_ready=0 throughout, FIFO_DEPTH=64 -> exactly 4 bursts of 16 issued, then read stays 0. Set pix_ready=1 -> issue resumes once 16 words are freed.
- frame_start with base 0x0020_0000 mid-burst after 5 of 16 beats -> 11 beats discarded, FIFO empty, next burst at 0x200000, next word out carries pix_sof=1.
- Memory latency 40 cycles, pix_ready=1 from frame_start -> underflow=1 and stays 1. Next frame_start clears it.
- Assert reset during RECEIVE -> all outputs at reset values immediately (asynchronous), no read issued until a new frame_start.

Source files
------------

// File: rtl/frame_scanout_reader.sv
// Avalon-MM burst-read master that streams one frame buffer from SDRAM into a word FIFO
// and presents it as a valid/ready pixel-word stream, restarting on every frame_start.
module frame_scanout_reader #(
    parameter int unsigned FRAME_WORDS = 153600,
    parameter int unsigned BURST_LEN   = 16,
    parameter int unsigned FIFO_DEPTH  = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] frame_address,
    input  logic        frame_start,
    output logic [31:0] avalon_master_address,
    output logic [4:0]  avalon_master_burstcount,
    output logic [3:0]  avalon_master_byteenable,
    output logic        avalon_master_read,
    input  logic [31:0] avalon_master_readdata,
    input  logic        avalon_master_readdatavalid,
    input  logic        avalon_master_waitrequest,
    output logic [31:0] pix_data,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        pix_sof,
    output logic        underflow,
    output logic        frame_done
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned FCNT_W = PTR_W + 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ISSUE   = 2'd1;
    localparam logic [1:0] S_RECEIVE = 2'd2;
    localparam logic [1:0] S_DRAIN   = 2'd3;

    logic [1:0]        state, state_n;
    logic [31:0]       base, base_n;
    logic [31:0]       issued, issued_n;
    logic [31:0]       received, received_n;
    logic [31:0]       popped, popped_n;
    logic [4:0]        beats_left, beats_n;
    logic              read_n, done_n;
    logic [31:0]       addr_n;
    logic [4:0]        bc_n;
    logic              beat, push, pop;
    logic [4:0]        outstanding;
    logic              can_issue;
    logic [31:0]       next_addr;
    logic [4:0]        next_bc, first_bc;

    logic [31:0]       mem_data [FIFO_DEPTH];
    logic              mem_sof  [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, wr_n, rd_ptr, rd_n;
    logic [FCNT_W-1:0] fifo_count, cnt_n;
    logic              valid_n, sof_n, sof_armed, sof_arm_n;
    logic [31:0]       data_n;
    logic              active, active_n, underflow_n;

    // Words in the next burst: a full burst, or whatever is left of the frame.
    function automatic logic [4:0] burst_size(input logic [31:0] done_words);
        logic [31:0] rem;
        rem = 32'(FRAME_WORDS) - done_words;
        burst_size = (rem < 32'(BURST_LEN)) ? rem[4:0] : 5'(BURST_LEN);
    endfunction

    assign avalon_master_byteenable = 4'hF;

    assign next_addr   = base + {issued[29:0], 2'b00};
    assign next_bc     = burst_size(issued);
    assign first_bc    = burst_size(32'd0);
    assign can_issue   = ((32'(FIFO_DEPTH) - 32'(fifo_count)) >= 32'(BURST_LEN)) &&
                         (issued < 32'(FRAME_WORDS));
    assign beat        = avalon_master_readdatavalid && (beats_left != 5'd0);
    assign outstanding = beats_left - 5'(beat);
    assign pop         = pix_valid && pix_ready;

    // Burst sequencing; frame_start overrides whatever the state was doing.
    always_comb begin
        state_n    = state;
        base_n     = base;
        issued_n   = issued;
        received_n = received;
        beats_n    = beats_left;
        read_n     = avalon_master_read;
        addr_n     = avalon_master_address;
        bc_n       = avalon_master_burstcount;
        done_n     = 1'b0;
        push       = 1'b0;
        case (state)
            S_ISSUE: begin
                if (!avalon_master_waitrequest) begin
                    read_n   = 1'b0;
                    issued_n = issued + 32'(avalon_master_burstcount);
                    beats_n  = avalon_master_burstcount;
                    state_n  = S_RECEIVE;
                end
            end
            S_RECEIVE: begin
                if (beats_left != 5'd0) begin
                    if (beat) begin
                        push       = 1'b1;
                        beats_n    = beats_left - 5'd1;
                        received_n = received + 32'd1;
                        if (received + 32'd1 == 32'(FRAME_WORDS)) begin
                            done_n  = 1'b1;
                            state_n = S_IDLE;
                        end
                    end
                end else if (can_issue) begin
                    state_n = S_ISSUE;
                    read_n  = 1'b1;
                    addr_n  = next_addr;
                    bc_n    = next_bc;
                end
            end
            S_DRAIN: begin
                if (beat) begin
                    beats_n = beats_left - 5'd1;
                    if (beats_left == 5'd1) begin
                        state_n = S_ISSUE;
                        read_n  = 1'b1;
                        addr_n  = next_addr;
                        bc_n    = next_bc;
                    end
                end
            end
            default: ;
        endcase
        if (frame_start) begin
            base_n     = frame_address;
            issued_n   = 32'd0;
            received_n = 32'd0;
            push       = 1'b0;
            done_n     = 1'b0;
            read_n     = 1'b0;
            if (state == S_ISSUE && !avalon_master_waitrequest) begin
                // The slave took the command this cycle, so its beats must be thrown away.
                state_n = S_DRAIN;
                beats_n = avalon_master_burstcount;
            end else if (state == S_ISSUE) begin
                state_n = S_RECEIVE;
                beats_n = 5'd0;
            end else if (outstanding != 5'd0) begin
                state_n = S_DRAIN;
                beats_n = outstanding;
            end else begin
                state_n = S_ISSUE;
                read_n  = 1'b1;
                addr_n  = frame_address;
                bc_n    = first_bc;
                beats_n = 5'd0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                    <= S_IDLE;
            base                     <= 32'd0;
            issued                   <= 32'd0;
            received                 <= 32'd0;
            beats_left               <= 5'd0;
            avalon_master_read       <= 1'b0;
            avalon_master_address    <= 32'd0;
            avalon_master_burstcount <= 5'd0;
            frame_done               <= 1'b0;
        end else begin
            state                    <= state_n;
            base                     <= base_n;
            issued                   <= issued_n;
            received                 <= received_n;
            beats_left               <= beats_n;
            avalon_master_read       <= read_n;
            avalon_master_address    <= addr_n;
            avalon_master_burstcount <= bc_n;
            frame_done               <= done_n;
        end
    end

    // FIFO bookkeeping with a registered head word, plus underflow tracking.
    always_comb begin
        wr_n        = wr_ptr;
        rd_n        = rd_ptr;
        cnt_n       = fifo_count;
        valid_n     = pix_valid;
        data_n      = pix_data;
        sof_n       = pix_sof;
        sof_arm_n   = sof_armed;
        popped_n    = popped;
        active_n    = active;
        underflow_n = underflow;
        if (frame_start) begin
            wr_n        = '0;
            rd_n        = '0;
            cnt_n       = '0;
            valid_n     = 1'b0;
            sof_arm_n   = 1'b1;
            popped_n    = 32'd0;
            active_n    = 1'b1;
            underflow_n = 1'b0;
        end else begin
            if (push) begin
                wr_n      = wr_ptr + PTR_W'(1);
                sof_arm_n = 1'b0;
            end
            if (pop) begin
                rd_n     = rd_ptr + PTR_W'(1);
                popped_n = popped + 32'd1;
                if (popped + 32'd1 == 32'(FRAME_WORDS)) begin
                    active_n = 1'b0;
                end
            end
            cnt_n   = fifo_count + FCNT_W'(push) - FCNT_W'(pop);
            valid_n = (cnt_n != '0);
            // An incoming word becomes the head only if nothing older remains after the pop.
            if (fifo_count == FCNT_W'(pop)) begin
                if (push) begin
                    data_n = avalon_master_readdata;
                    sof_n  = sof_armed;
                end
            end else if (pop) begin
                data_n = mem_data[rd_n];
                sof_n  = mem_sof[rd_n];
            end
            if (pix_ready && !pix_valid && active) begin
                underflow_n = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            pix_valid  <= 1'b0;
            pix_data   <= 32'd0;
            pix_sof    <= 1'b0;
            sof_armed  <= 1'b0;
            popped     <= 32'd0;
            active     <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            wr_ptr     <= wr_n;
            rd_ptr     <= rd_n;
            fifo_count <= cnt_n;
            pix_valid  <= valid_n;
            pix_data   <= data_n;
            pix_sof    <= sof_n;
            sof_armed  <= sof_arm_n;
            popped     <= popped_n;
            active     <= active_n;
            underflow  <= underflow_n;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= avalon_master_readdata;
            mem_sof[wr_ptr]  <= sof_armed;
        end
    end

endmodule

// File: tb/tb_frame_scanout_reader.sv
// Scoreboard bench for frame_scanout_reader: an Avalon memory model feeds bursts, and a
// monitor checks every streamed word against the frame contents computed from its base.
module tb_frame_scanout_reader;

    localparam int unsigned FW = 72;
    localparam int unsigned BL = 16;
    localparam int unsigned FD = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] frame_address;
    logic        frame_start;
    logic [31:0] address;
    logic [4:0]  burstcount;
    logic [3:0]  byteenable;
    logic        read;
    logic [31:0] readdata;
    logic        readdatavalid;
    logic        waitrequest;
    logic [31:0] pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic        pix_sof;
    logic        underflow;
    logic        frame_done;

    frame_scanout_reader #(.FRAME_WORDS(FW), .BURST_LEN(BL), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .reset(rst),
        .frame_address(frame_address), .frame_start(frame_start),
        .avalon_master_address(address), .avalon_master_burstcount(burstcount),
        .avalon_master_byteenable(byteenable), .avalon_master_read(read),
        .avalon_master_readdata(readdata), .avalon_master_readdatavalid(readdatavalid),
        .avalon_master_waitrequest(waitrequest),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_sof(pix_sof),
        .underflow(underflow), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] d;
        logic        s;
    } exp_t;

    int total = 0;
    int bad   = 0;
    exp_t exp_q[$];
    logic [31:0] beat_data[$];
    int beat_due[$];
    int cyc = 0;
    int lat = 2;
    int stall_left = 0;
    bit rand_wr = 1'b0;
    bit rand_ready = 1'b0;
    logic [31:0] exp_base = 32'd0;
    int exp_issued = 0;
    int bursts_in_frame = 0;
    int beats_seen = 0;
    int first_accept_beats = -1;
    int read_seen = 0;
    int fd_count = 0;
    bit prev_stalled = 1'b0;
    logic [31:0] prev_addr;
    logic [4:0] prev_bc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    // Memory model: command acceptance, burst checks and beat delivery after a latency.
    initial begin
        readdatavalid = 1'b0;
        readdata      = 32'd0;
        waitrequest   = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                beat_data.delete();
                beat_due.delete();
                prev_stalled  = 1'b0;
                readdatavalid = 1'b0;
                waitrequest   = 1'b0;
            end else begin
                if (prev_stalled) begin
                    chk("hold_read", 32'(read), 32'd1);
                    chk("hold_address", address, prev_addr);
                    chk("hold_burstcount", 32'(burstcount), 32'(prev_bc));
                end
                if (beat_due.size() > 0 && beat_due[0] <= cyc) begin
                    readdatavalid = 1'b1;
                    readdata      = beat_data.pop_front();
                    void'(beat_due.pop_front());
                    beats_seen++;
                end else begin
                    readdatavalid = 1'b0;
                    readdata      = $urandom;
                end
                if (read) begin
                    read_seen++;
                    if (stall_left > 0) begin
                        waitrequest = 1'b1;
                        stall_left--;
                    end else begin
                        waitrequest = rand_wr ? ($urandom_range(0, 2) == 0) : 1'b0;
                    end
                end else begin
                    waitrequest = 1'b0;
                end
                if (read && !waitrequest) begin
                    chk("one_outstanding", 32'(beat_due.size()), 32'd0);
                    if (!frame_start) begin
                        int rem;
                        rem = int'(FW) - exp_issued;
                        if (bursts_in_frame == 0) first_accept_beats = beats_seen;
                        chk("burst_address", address, exp_base + 32'(4 * exp_issued));
                        chk("burst_count", 32'(burstcount), 32'((rem < int'(BL)) ? rem : int'(BL)));
                        exp_issued += int'(burstcount);
                        bursts_in_frame++;
                    end
                    for (int k = 0; k < int'(burstcount); k++) begin
                        beat_data.push_back(mem_word(address + 32'(4 * k)));
                        beat_due.push_back(cyc + lat + k);
                    end
                end
                prev_stalled = read && waitrequest && !frame_start;
                prev_addr    = address;
                prev_bc      = burstcount;
            end
        end
    end

    // Output monitor: every accepted word is compared with the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            if (frame_done) fd_count++;
            if (!rst && !frame_start && pix_valid && pix_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_word", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("pix_data", pix_data, e.d);
                    chk("pix_sof", 32'(pix_sof), 32'(e.s));
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
            if (rand_ready) pix_ready = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic start_frame(input logic [31:0] b);
        frame_address      = b;
        frame_start        = 1'b1;
        exp_base           = b;
        exp_issued         = 0;
        bursts_in_frame    = 0;
        beats_seen         = 0;
        first_accept_beats = -1;
        fd_count           = 0;
        exp_q.delete();
        for (int i = 0; i < int'(FW); i++) begin
            exp_q.push_back('{d: mem_word(b + 32'(4 * i)), s: (i == 0)});
        end
        tick();
        frame_start = 1'b0;
    endtask

    task automatic wait_frame(input string name);
        int n;
        n = 0;
        while (!(fd_count >= 1 && exp_q.size() == 0) && n < 3000) begin
            tick();
            n++;
        end
        if (n >= 3000) chk({name, "_timeout"}, 32'd1, 32'd0);
        tick(3);
        chk({name, "_done_pulses"}, 32'(fd_count), 32'd1);
        chk({name, "_stream_idle"}, 32'(pix_valid), 32'd0);
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, "_read"}, 32'(read), 32'd0);
        chk({name, "_address"}, address, 32'd0);
        chk({name, "_burstcount"}, 32'(burstcount), 32'd0);
        chk({name, "_pix_valid"}, 32'(pix_valid), 32'd0);
        chk({name, "_pix_sof"}, 32'(pix_sof), 32'd0);
        chk({name, "_underflow"}, 32'(underflow), 32'd0);
        chk({name, "_frame_done"}, 32'(frame_done), 32'd0);
    endtask

    initial begin
        int n;
        rst           = 1'b1;
        frame_address = 32'd0;
        frame_start   = 1'b0;
        pix_ready     = 1'b0;
        tick(2);
        check_reset_outputs("reset");
        chk("byteenable", 32'(byteenable), 32'hF);
        rst = 1'b0;
        tick(3);
        chk("idle_no_read", 32'(read), 32'd0);

        // Ideal memory, consumer always ready, second burst stalled five cycles.
        pix_ready = 1'b1;
        lat = 2;
        start_frame(32'h0010_0000);
        n = 0;
        while (bursts_in_frame < 1 && n < 200) begin tick(); n++; end
        stall_left = 5;
        wait_frame("ideal");
        chk("ideal_bursts", 32'(bursts_in_frame), 32'd5);

        // Consumer stalled: the FIFO fills with four bursts and issue stops.
        pix_ready = 1'b0;
        start_frame(32'h0030_0000);
        tick(300);
        chk("bp_bursts", 32'(bursts_in_frame), 32'd4);
        chk("bp_read_idle", 32'(read), 32'd0);
        chk("bp_fifo_valid", 32'(pix_valid), 32'd1);
        pix_ready = 1'b1;
        wait_frame("bp");
        chk("bp_bursts_total", 32'(bursts_in_frame), 32'd5);

        // New frame after 5 of 16 beats: the remaining 11 are discarded.
        pix_ready = 1'b0;
        start_frame(32'h0040_0000);
        n = 0;
        while (beats_seen < 5 && n < 200) begin tick(); n++; end
        chk("abort_beats_before", 32'(beats_seen), 32'd5);
        start_frame(32'h0020_0000);
        chk("abort_flush", 32'(pix_valid), 32'd0);
        n = 0;
        while (bursts_in_frame < 1 && n < 200) begin tick(); n++; end
        chk("abort_reissued", 32'(bursts_in_frame >= 1), 32'd1);
        chk("abort_discarded", 32'(first_accept_beats), 32'd11);
        pix_ready = 1'b1;
        wait_frame("abort");

        // Random bases, latencies, stalls and consumer back-pressure, including address wrap.
        rand_wr    = 1'b1;
        rand_ready = 1'b1;
        for (int f = 0; f < 4; f++) begin
            lat = $urandom_range(1, 6);
            start_frame((f == 0) ? 32'hFFFF_FF00 : ($urandom & 32'hFFFF_FFFC));
            wait_frame("random");
        end
        rand_wr    = 1'b0;
        rand_ready = 1'b0;

        // Slow memory with an eager consumer: underflow sets and sticks until frame_start.
        lat = 40;
        pix_ready = 1'b1;
        start_frame(32'h0050_0000);
        tick(60);
        chk("underflow_set", 32'(underflow), 32'd1);
        tick(40);
        chk("underflow_sticky", 32'(underflow), 32'd1);
        pix_ready = 1'b0;
        start_frame(32'h0060_0000);
        chk("underflow_cleared", 32'(underflow), 32'd0);
        chk("restart_flush", 32'(pix_valid), 32'd0);
        lat = 2;
        pix_ready = 1'b1;
        wait_frame("slow_restart");

        // Asynchronous reset while beats are arriving.
        lat = 8;
        pix_ready = 1'b0;
        start_frame(32'h0070_0000);
        n = 0;
        while (beats_seen < 3 && n < 200) begin tick(); n++; end
        chk("pre_reset_valid", 32'(pix_valid), 32'd1);
        rst = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        exp_q.delete();
        tick(3);
        rst = 1'b0;
        read_seen = 0;
        tick(30);
        chk("post_reset_no_read", 32'(read_seen), 32'd0);
        lat = 3;
        pix_ready = 1'b1;
        start_frame(32'h0080_0000);
        wait_frame("after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
